// File: rtl/pipeline_latches.sv
// pipeline_latches
//   Inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) of the 5-stage MIPS core.
//   Each latch applies flush > hold > load, driven by the hazard unit's controls.
//   A data-cache miss in MEM (dmem_req & ~dhit) freezes all four latches together.
//   Three saturating counters (stall, flush, freeze) support performance debug.
//
// Ports
//   CLK, nRST                      clock (rising edge), async active-low reset
//   ihit, dhit, dmem_req           cache status / MEM-stage access pending
//   flush_ID/EX/MEM                bubble the latch feeding that stage
//   enable_ID/EX/MEM               0 = hold the latch feeding that stage
//   instr_IF, npc_IF               fetched instruction and PC+4
//   dec_ID, exr_EX, memr_MEM       per-stage payloads captured downstream
//   instr_*/npc_*/valid_* ...      latch contents per stage
//   stall_cnt, flush_cnt, freeze_cnt  saturating performance counters
module pipeline_latches #(
  parameter int WORD_W = 32,
  parameter int DEC_W  = 96,
  parameter int EXR_W  = 32,
  parameter int MEMR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              nRST,
  input  logic              ihit,
  input  logic              dhit,
  input  logic              dmem_req,
  input  logic              flush_ID,
  input  logic              flush_EX,
  input  logic              flush_MEM,
  input  logic              enable_ID,
  input  logic              enable_EX,
  input  logic              enable_MEM,
  input  logic [WORD_W-1:0] instr_IF,
  input  logic [WORD_W-1:0] npc_IF,
  input  logic [DEC_W-1:0]  dec_ID,
  input  logic [EXR_W-1:0]  exr_EX,
  input  logic [MEMR_W-1:0] memr_MEM,
  output logic [WORD_W-1:0] instr_ID,
  output logic [WORD_W-1:0] npc_ID,
  output logic              valid_ID,
  output logic [WORD_W-1:0] instr_EX,
  output logic [WORD_W-1:0] npc_EX,
  output logic [DEC_W-1:0]  dec_EX,
  output logic              valid_EX,
  output logic [WORD_W-1:0] instr_MEM,
  output logic [WORD_W-1:0] npc_MEM,
  output logic [EXR_W-1:0]  exr_MEM,
  output logic              valid_MEM,
  output logic [WORD_W-1:0] instr_WB,
  output logic [WORD_W-1:0] npc_WB,
  output logic [EXR_W-1:0]  exr_WB,
  output logic [MEMR_W-1:0] memr_WB,
  output logic              valid_WB,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt,
  output logic [CNT_W-1:0]  freeze_cnt
);

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  logic w_freeze;
  assign w_freeze = dmem_req & ~dhit;

  logic [WORD_W-1:0] r_instr_id, r_npc_id;
  logic              r_valid_id;
  logic [WORD_W-1:0] r_instr_ex, r_npc_ex;
  logic [DEC_W-1:0]  r_dec_ex;
  logic              r_valid_ex;
  logic [WORD_W-1:0] r_instr_mem, r_npc_mem;
  logic [EXR_W-1:0]  r_exr_mem;
  logic              r_valid_mem;
  logic [WORD_W-1:0] r_instr_wb, r_npc_wb;
  logic [EXR_W-1:0]  r_exr_wb;
  logic [MEMR_W-1:0] r_memr_wb;
  logic              r_valid_wb;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt, r_freeze_cnt;

  // IF/ID: a fetch miss (ihit=0) with the latch enabled inserts a bubble.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_instr_id <= '0;
      r_npc_id   <= '0;
      r_valid_id <= 1'b0;
    end else if (!w_freeze) begin
      if (flush_ID || (enable_ID && !ihit)) begin
        r_instr_id <= '0;
        r_npc_id   <= '0;
        r_valid_id <= 1'b0;
      end else if (enable_ID) begin
        r_instr_id <= instr_IF;
        r_npc_id   <= npc_IF;
        r_valid_id <= 1'b1;
      end
    end
  end

  // ID/EX
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_instr_ex <= '0;
      r_npc_ex   <= '0;
      r_dec_ex   <= '0;
      r_valid_ex <= 1'b0;
    end else if (!w_freeze) begin
      if (flush_EX) begin
        r_instr_ex <= '0;
        r_npc_ex   <= '0;
        r_dec_ex   <= '0;
        r_valid_ex <= 1'b0;
      end else if (enable_EX) begin
        r_instr_ex <= r_instr_id;
        r_npc_ex   <= r_npc_id;
        r_dec_ex   <= dec_ID;
        r_valid_ex <= r_valid_id;
      end
    end
  end

  // EX/MEM
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_instr_mem <= '0;
      r_npc_mem   <= '0;
      r_exr_mem   <= '0;
      r_valid_mem <= 1'b0;
    end else if (!w_freeze) begin
      if (flush_MEM) begin
        r_instr_mem <= '0;
        r_npc_mem   <= '0;
        r_exr_mem   <= '0;
        r_valid_mem <= 1'b0;
      end else if (enable_MEM) begin
        r_instr_mem <= r_instr_ex;
        r_npc_mem   <= r_npc_ex;
        r_exr_mem   <= exr_EX;
        r_valid_mem <= r_valid_ex;
      end
    end
  end

  // MEM/WB: no hazard control, only the freeze stops it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_instr_wb <= '0;
      r_npc_wb   <= '0;
      r_exr_wb   <= '0;
      r_memr_wb  <= '0;
      r_valid_wb <= 1'b0;
    end else if (!w_freeze) begin
      r_instr_wb <= r_instr_mem;
      r_npc_wb   <= r_npc_mem;
      r_exr_wb   <= r_exr_mem;
      r_memr_wb  <= memr_MEM;
      r_valid_wb <= r_valid_mem;
    end
  end

  // Counters: a flush on IF/ID outranks a simultaneous hold, so it never counts as a stall.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_stall_cnt  <= '0;
      r_flush_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else if (w_freeze) begin
      r_freeze_cnt <= sat_inc(r_freeze_cnt);
    end else if (flush_ID) begin
      r_flush_cnt  <= sat_inc(r_flush_cnt);
    end else if (!enable_ID) begin
      r_stall_cnt  <= sat_inc(r_stall_cnt);
    end
  end

  assign instr_ID   = r_instr_id;
  assign npc_ID     = r_npc_id;
  assign valid_ID   = r_valid_id;
  assign instr_EX   = r_instr_ex;
  assign npc_EX     = r_npc_ex;
  assign dec_EX     = r_dec_ex;
  assign valid_EX   = r_valid_ex;
  assign instr_MEM  = r_instr_mem;
  assign npc_MEM    = r_npc_mem;
  assign exr_MEM    = r_exr_mem;
  assign valid_MEM  = r_valid_mem;
  assign instr_WB   = r_instr_wb;
  assign npc_WB     = r_npc_wb;
  assign exr_WB     = r_exr_wb;
  assign memr_WB    = r_memr_wb;
  assign valid_WB   = r_valid_wb;
  assign stall_cnt  = r_stall_cnt;
  assign flush_cnt  = r_flush_cnt;
  assign freeze_cnt = r_freeze_cnt;

endmodule

// File: tb/tb_pipeline_latches.sv
module tb_pipeline_latches;
  localparam int WORD_W = 32;
  localparam int DEC_W  = 96;
  localparam int EXR_W  = 32;
  localparam int MEMR_W = 32;
  localparam int CNT_W  = 4;

  logic              CLK = 1'b0;
  logic              nRST;
  logic              ihit, dhit, dmem_req;
  logic              flush_ID, flush_EX, flush_MEM;
  logic              enable_ID, enable_EX, enable_MEM;
  logic [WORD_W-1:0] instr_IF, npc_IF;
  logic [DEC_W-1:0]  dec_ID;
  logic [EXR_W-1:0]  exr_EX;
  logic [MEMR_W-1:0] memr_MEM;
  logic [WORD_W-1:0] instr_ID, npc_ID, instr_EX, npc_EX, instr_MEM, npc_MEM;
  logic [WORD_W-1:0] instr_WB, npc_WB;
  logic [DEC_W-1:0]  dec_EX;
  logic [EXR_W-1:0]  exr_MEM, exr_WB;
  logic [MEMR_W-1:0] memr_WB;
  logic              valid_ID, valid_EX, valid_MEM, valid_WB;
  logic [CNT_W-1:0]  stall_cnt, flush_cnt, freeze_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  pipeline_latches #(
    .WORD_W(WORD_W), .DEC_W(DEC_W), .EXR_W(EXR_W), .MEMR_W(MEMR_W), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit), .dmem_req(dmem_req),
    .flush_ID(flush_ID), .flush_EX(flush_EX), .flush_MEM(flush_MEM),
    .enable_ID(enable_ID), .enable_EX(enable_EX), .enable_MEM(enable_MEM),
    .instr_IF(instr_IF), .npc_IF(npc_IF), .dec_ID(dec_ID), .exr_EX(exr_EX),
    .memr_MEM(memr_MEM),
    .instr_ID(instr_ID), .npc_ID(npc_ID), .valid_ID(valid_ID),
    .instr_EX(instr_EX), .npc_EX(npc_EX), .dec_EX(dec_EX), .valid_EX(valid_EX),
    .instr_MEM(instr_MEM), .npc_MEM(npc_MEM), .exr_MEM(exr_MEM), .valid_MEM(valid_MEM),
    .instr_WB(instr_WB), .npc_WB(npc_WB), .exr_WB(exr_WB), .memr_WB(memr_WB),
    .valid_WB(valid_WB),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One rising edge; outputs are read 1 time unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic defaults();
    ihit = 1'b0; dhit = 1'b0; dmem_req = 1'b0;
    flush_ID = 1'b0; flush_EX = 1'b0; flush_MEM = 1'b0;
    enable_ID = 1'b1; enable_EX = 1'b1; enable_MEM = 1'b1;
    instr_IF = '0; npc_IF = '0; dec_ID = '0; exr_EX = '0; memr_MEM = '0;
  endtask

  task automatic do_reset();
    nRST = 1'b0;
    #2;
    defaults();
    nRST = 1'b1;
    #1;
  endtask

  initial begin
    defaults();
    nRST = 1'b1;
    #2;

    // 1: reset with random inputs
    ihit = 1'b1; dhit = 1'($urandom); dmem_req = 1'b0;
    flush_ID = 1'($urandom); enable_ID = 1'b1;
    instr_IF = $urandom; npc_IF = $urandom;
    dec_ID = {$urandom, $urandom, $urandom}; exr_EX = $urandom; memr_MEM = $urandom;
    step();
    step();
    nRST = 1'b0;
    #1;
    chk("rst_instr_ID", instr_ID, 0);
    chk("rst_valid_ID", valid_ID, 0);
    chk("rst_dec_EX", dec_EX, 0);
    chk("rst_instr_WB", instr_WB, 0);
    chk("rst_valid_WB", valid_WB, 0);
    chk("rst_memr_WB", memr_WB, 0);
    chk("rst_flush_cnt", flush_cnt, 0);
    step();
    chk("rst_hold_valid_MEM", valid_MEM, 0);
    chk("rst_hold_exr_MEM", exr_MEM, 0);
    defaults();
    nRST = 1'b1;
    ihit = 1'b1; instr_IF = 32'h2008_0005; npc_IF = 32'h0000_0004;
    step();
    chk("first_instr_ID", instr_ID, 32'h2008_0005);
    chk("first_valid_ID", valid_ID, 1);
    chk("first_npc_ID", npc_ID, 32'h4);

    // 2: flow of A..D
    do_reset();
    ihit = 1'b1;
    dec_ID = 96'hDEC0_0000_0000_0000_0000_0001; exr_EX = 32'hE0E0_0001; memr_MEM = 32'hAA55_0001;
    instr_IF = 32'hA; npc_IF = 32'h104; step();
    chk("flow1_ID", instr_ID, 32'hA);
    chk("flow1_EX", instr_EX, 0);
    instr_IF = 32'hB; npc_IF = 32'h108; step();
    chk("flow2_ID", instr_ID, 32'hB);
    chk("flow2_EX", instr_EX, 32'hA);
    chk("flow2_dec_EX", dec_EX, 96'hDEC0_0000_0000_0000_0000_0001);
    chk("flow2_valid_EX", valid_EX, 1);
    instr_IF = 32'hC; npc_IF = 32'h10C; step();
    chk("flow3_MEM", instr_MEM, 32'hA);
    chk("flow3_exr_MEM", exr_MEM, 32'hE0E0_0001);
    chk("flow3_EX", instr_EX, 32'hB);
    instr_IF = 32'hD; npc_IF = 32'h110; step();
    chk("flow4_WB", instr_WB, 32'hA);
    chk("flow4_npc_WB", npc_WB, 32'h104);
    chk("flow4_valid_WB", valid_WB, 1);
    chk("flow4_memr_WB", memr_WB, 32'hAA55_0001);
    chk("flow4_MEM", instr_MEM, 32'hB);
    chk("flow4_EX", instr_EX, 32'hC);
    chk("flow4_ID", instr_ID, 32'hD);

    // 3: load-use stall (state: ID=D EX=C MEM=B WB=A)
    instr_IF = 32'hE; npc_IF = 32'h114;
    enable_ID = 1'b0; flush_EX = 1'b1;
    step();
    chk("lu_ID_hold", instr_ID, 32'hD);
    chk("lu_EX_bubble", instr_EX, 0);
    chk("lu_valid_EX", valid_EX, 0);
    chk("lu_dec_EX", dec_EX, 0);
    chk("lu_MEM_adv", instr_MEM, 32'hC);
    chk("lu_WB_adv", instr_WB, 32'hB);
    chk("lu_stall_cnt", stall_cnt, 1);
    chk("lu_flush_cnt", flush_cnt, 0);
    enable_ID = 1'b1; flush_EX = 1'b0;

    // 4: jump flush (state: ID=D EX=0 MEM=C WB=B)
    flush_ID = 1'b1; flush_EX = 1'b1; flush_MEM = 1'b1;
    step();
    chk("jmp_ID", instr_ID, 0);
    chk("jmp_valid_ID", valid_ID, 0);
    chk("jmp_EX", instr_EX, 0);
    chk("jmp_MEM", instr_MEM, 0);
    chk("jmp_valid_MEM", valid_MEM, 0);
    chk("jmp_WB", instr_WB, 32'hC);
    chk("jmp_valid_WB", valid_WB, 1);
    chk("jmp_flush_cnt", flush_cnt, 1);
    // flush and hold together count as a flush only
    flush_EX = 1'b0; flush_MEM = 1'b0; enable_ID = 1'b0;
    step();
    chk("fh_flush_cnt", flush_cnt, 2);
    chk("fh_stall_cnt", stall_cnt, 1);
    chk("fh_valid_ID", valid_ID, 0);
    defaults();

    // 5: freeze
    do_reset();
    ihit = 1'b1;
    instr_IF = 32'h11; step();
    instr_IF = 32'h22; step();
    instr_IF = 32'h33; step();
    chk("fz_pre_MEM", instr_MEM, 32'h11);
    instr_IF = 32'h44; dmem_req = 1'b1; dhit = 1'b0; flush_EX = 1'b1;
    step(); step(); step();
    chk("fz_ID", instr_ID, 32'h33);
    chk("fz_EX", instr_EX, 32'h22);
    chk("fz_valid_EX", valid_EX, 1);
    chk("fz_MEM", instr_MEM, 32'h11);
    chk("fz_WB", instr_WB, 0);
    chk("fz_freeze_cnt", freeze_cnt, 3);
    chk("fz_flush_cnt", flush_cnt, 0);
    dhit = 1'b1; flush_EX = 1'b0;
    step();
    chk("thaw_ID", instr_ID, 32'h44);
    chk("thaw_EX", instr_EX, 32'h33);
    chk("thaw_MEM", instr_MEM, 32'h22);
    chk("thaw_WB", instr_WB, 32'h11);
    chk("thaw_freeze_cnt", freeze_cnt, 3);
    // reset in the middle of a freeze clears everything
    dhit = 1'b0;
    step();
    nRST = 1'b0;
    #1;
    chk("fzrst_ID", instr_ID, 0);
    chk("fzrst_freeze_cnt", freeze_cnt, 0);
    defaults();
    nRST = 1'b1;
    ihit = 1'b1; instr_IF = 32'h55;
    step();
    chk("fzrst_load_ID", instr_ID, 32'h55);
    chk("fzrst_EX", instr_EX, 0);

    // 6: counter saturation, then fetch miss
    do_reset();
    ihit = 1'b1; instr_IF = 32'h66; step();
    enable_ID = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("sat_stall_cnt", stall_cnt, 15);
    chk("sat_ID_hold", instr_ID, 32'h66);
    chk("sat_valid_ID", valid_ID, 1);
    enable_ID = 1'b1; ihit = 1'b0;
    step();
    chk("miss_instr_ID", instr_ID, 0);
    chk("miss_valid_ID", valid_ID, 0);
    chk("miss_stall_cnt", stall_cnt, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
